// File: rtl/adc_scan_pkg.sv
// adc_scan_pkg
// Shared types and default constants for the ADC scan sequencer.
//   conv_state_e : conversion FSM states
//   *_DEF        : default parameter values for the top and sub-modules
//   cnt_width    : counter width for a modulus, never below 1 bit
package adc_scan_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        WAIT,
        STORE,
        SKIP
    } conv_state_e;

    localparam int unsigned NUM_CH_DEF     = 8;
    localparam int unsigned DATA_W_DEF     = 10;
    localparam int unsigned TICK_DIV_DEF   = 16384;
    localparam int unsigned DEB_LEN_DEF    = 10;
    localparam int unsigned SCAN_DWELL_DEF = 64;
    localparam int unsigned TIMEOUT_DEF    = 4096;

    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/adc_scan_sequencer_key_debounce.sv
// key_debounce
// Tick-sampled debouncer for one active-low key. Emits a single-cycle
// press pulse when a low sample follows DEB_LEN consecutive high samples.
// Ports:
//   clk_i   : clock
//   rst_i   : asynchronous active-high reset (history cleared to all 0)
//   tick_i  : sample strobe
//   key_i   : raw key, active-low (expected already synchronous to clk_i)
//   press_o : one-cycle press event, registered
module key_debounce
    import adc_scan_pkg::*;
#(
    parameter int unsigned DEB_LEN = DEB_LEN_DEF
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic tick_i,
    input  logic key_i,
    output logic press_o
);

    logic [DEB_LEN-1:0] hist_q;
    logic               press_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            hist_q  <= '0;
            press_q <= 1'b0;
        end else begin
            // Once the low sample enters the history it is no longer
            // all-ones, so a held key cannot re-trigger.
            press_q <= tick_i & ~key_i & (&hist_q);
            if (tick_i) begin
                hist_q <= {hist_q[DEB_LEN-2:0], key_i};
            end
        end
    end

    assign press_o = press_q;

endmodule

// File: rtl/adc_scan_sequencer.sv
// adc_scan_sequencer
// Round-robin converts NUM_CH channels through an external ADC controller
// (start/done handshake), keeps the latest result per channel and drives
// the display path with a manually stepped or auto-scanned channel.
// Ports:
//   clk_50M, rst            : clock, asynchronous active-high reset
//   key_next, key_mode      : raw active-low keys (step channel / toggle auto)
//   adc_start, adc_channel  : conversion request and channel
//   adc_done, adc_data      : conversion complete pulse and result
//   disp_channel/data/valid : channel shown, its stored result, result seen
//   auto_mode               : auto-scan active
//   timeout_err             : sticky ADC timeout flag
module adc_scan_sequencer
    import adc_scan_pkg::*;
#(
    parameter  int unsigned NUM_CH     = NUM_CH_DEF,
    parameter  int unsigned DATA_W     = DATA_W_DEF,
    parameter  int unsigned TICK_DIV   = TICK_DIV_DEF,
    parameter  int unsigned DEB_LEN    = DEB_LEN_DEF,
    parameter  int unsigned SCAN_DWELL = SCAN_DWELL_DEF,
    parameter  int unsigned TIMEOUT    = TIMEOUT_DEF,
    localparam int unsigned CH_W       = $clog2(NUM_CH)
) (
    input  logic              clk_50M,
    input  logic              rst,
    input  logic              key_next,
    input  logic              key_mode,
    output logic              adc_start,
    output logic [CH_W-1:0]   adc_channel,
    input  logic              adc_done,
    input  logic [DATA_W-1:0] adc_data,
    output logic [CH_W-1:0]   disp_channel,
    output logic [DATA_W-1:0] disp_data,
    output logic              disp_valid,
    output logic              auto_mode,
    output logic              timeout_err
);

    localparam int unsigned TD_W = cnt_width(TICK_DIV);
    localparam int unsigned DW_W = cnt_width(SCAN_DWELL);
    localparam int unsigned TO_W = cnt_width(TIMEOUT);

    // Explicit wrap so non power-of-two channel counts stay in range.
    function automatic logic [CH_W-1:0] ch_inc(input logic [CH_W-1:0] c);
        return (c == CH_W'(NUM_CH - 1)) ? '0 : c + CH_W'(1);
    endfunction

    // ---------------- key sample tick ----------------
    logic [TD_W-1:0] tdiv_q;
    logic            tick_q;

    always_ff @(posedge clk_50M or posedge rst) begin
        if (rst) begin
            tdiv_q <= '0;
            tick_q <= 1'b0;
        end else begin
            tick_q <= (tdiv_q == TD_W'(TICK_DIV - 1));
            tdiv_q <= (tdiv_q == TD_W'(TICK_DIV - 1)) ? '0 : tdiv_q + TD_W'(1);
        end
    end

    // ---------------- key debouncers ----------------
    logic next_press;
    logic mode_press;

    key_debounce #(.DEB_LEN(DEB_LEN)) u_deb_next (
        .clk_i   (clk_50M),
        .rst_i   (rst),
        .tick_i  (tick_q),
        .key_i   (key_next),
        .press_o (next_press)
    );

    key_debounce #(.DEB_LEN(DEB_LEN)) u_deb_mode (
        .clk_i   (clk_50M),
        .rst_i   (rst),
        .tick_i  (tick_q),
        .key_i   (key_mode),
        .press_o (mode_press)
    );

    // ---------------- display channel / mode ----------------
    logic            auto_q,    auto_d;
    logic [DW_W-1:0] dwell_q,   dwell_d;
    logic [CH_W-1:0] disp_ch_q, disp_ch_d;

    always_comb begin
        auto_d    = auto_q;
        dwell_d   = dwell_q;
        disp_ch_d = disp_ch_q;
        // Channel stepping uses the mode in force before any toggle.
        if (auto_q) begin
            if (tick_q) begin
                if (dwell_q == DW_W'(SCAN_DWELL - 1)) begin
                    dwell_d   = '0;
                    disp_ch_d = ch_inc(disp_ch_q);
                end else begin
                    dwell_d = dwell_q + DW_W'(1);
                end
            end
        end else if (next_press) begin
            disp_ch_d = ch_inc(disp_ch_q);
        end
        if (mode_press) begin
            auto_d = ~auto_q;
            if (!auto_q) begin
                dwell_d = '0;
            end
        end
    end

    always_ff @(posedge clk_50M or posedge rst) begin
        if (rst) begin
            auto_q    <= 1'b0;
            dwell_q   <= '0;
            disp_ch_q <= '0;
        end else begin
            auto_q    <= auto_d;
            dwell_q   <= dwell_d;
            disp_ch_q <= disp_ch_d;
        end
    end

    // ---------------- conversion FSM and result bank ----------------
    conv_state_e       state_q;
    logic [CH_W-1:0]   conv_ch_q;
    logic [TO_W-1:0]   wait_q;
    logic [DATA_W-1:0] data_q;
    logic              adc_start_q;
    logic [CH_W-1:0]   adc_ch_q;
    logic              err_q;
    logic [DATA_W-1:0] result_q [NUM_CH];
    logic [NUM_CH-1:0] valid_q;

    always_ff @(posedge clk_50M or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            conv_ch_q   <= '0;
            wait_q      <= '0;
            data_q      <= '0;
            adc_start_q <= 1'b0;
            adc_ch_q    <= '0;
            err_q       <= 1'b0;
            valid_q     <= '0;
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                result_q[i] <= '0;
            end
        end else begin
            case (state_q)
                IDLE: begin
                    // Registered outputs are loaded one cycle ahead so they
                    // are asserted while the FSM sits in START.
                    adc_start_q <= 1'b1;
                    adc_ch_q    <= conv_ch_q;
                    state_q     <= START;
                end
                START: begin
                    adc_start_q <= 1'b0;
                    wait_q      <= '0;
                    state_q     <= WAIT;
                end
                WAIT: begin
                    // A done coinciding with the last wait cycle still stores.
                    if (adc_done) begin
                        data_q  <= adc_data;
                        state_q <= STORE;
                    end else if (wait_q == TO_W'(TIMEOUT - 1)) begin
                        state_q <= SKIP;
                    end else begin
                        wait_q <= wait_q + TO_W'(1);
                    end
                end
                STORE: begin
                    result_q[conv_ch_q] <= data_q;
                    valid_q[conv_ch_q]  <= 1'b1;
                    conv_ch_q           <= ch_inc(conv_ch_q);
                    state_q             <= IDLE;
                end
                SKIP: begin
                    err_q     <= 1'b1;
                    conv_ch_q <= ch_inc(conv_ch_q);
                    state_q   <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // ---------------- display data ----------------
    logic [DATA_W-1:0] disp_data_q;
    logic              disp_valid_q;

    always_ff @(posedge clk_50M or posedge rst) begin
        if (rst) begin
            disp_data_q  <= '0;
            disp_valid_q <= 1'b0;
        end else if (state_q == STORE && conv_ch_q == disp_ch_q) begin
            // Forward the value being stored so it shows the next cycle.
            disp_data_q  <= data_q;
            disp_valid_q <= 1'b1;
        end else begin
            disp_data_q  <= result_q[disp_ch_q];
            disp_valid_q <= valid_q[disp_ch_q];
        end
    end

    assign adc_start    = adc_start_q;
    assign adc_channel  = adc_ch_q;
    assign disp_channel = disp_ch_q;
    assign disp_data    = disp_data_q;
    assign disp_valid   = disp_valid_q;
    assign auto_mode    = auto_q;
    assign timeout_err  = err_q;

endmodule
